// File: rtl/mips32_pipeline.sv
// mips32_pipeline: 5-stage MIPS-like core with ALU forwarding and EX branch resolution.
// Define MIPS32_MUL_EN to build the MUL opcode (000101); otherwise it decodes as NOP.
module mips32_pipeline #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [31:0] NOP_IR = {OP_OR, 26'd0};

`ifdef MIPS32_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    // dst is zero for anything that does not write a register
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] lmd;
    } mem_wb_t;

    logic [31:0] Mem [0:MEM_DEPTH-1];
    logic [31:0] RegBank [0:31];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    if_id_t  if_id;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    function automatic logic [AW-1:0] widx(input logic [31:0] a);
        return AW'(a % 32'(MEM_DEPTH));
    endfunction

    logic        wb_we;
    logic [31:0] wb_val;

    assign wb_we  = (mem_wb.dst != 5'd0) && !HALTED;
    assign wb_val = (mem_wb.op == OP_LW) ? mem_wb.lmd : mem_wb.alu;

    logic [31:0] id_ir;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_dst;
    logic [31:0] id_imm;
    logic        id_rr;
    logic        id_ri;
    logic [31:0] rf_a;
    logic [31:0] rf_b;

    // the slot fetched while a taken branch resolved is wrong-path
    assign id_ir  = TAKEN_BRANCH ? NOP_IR : if_id.ir;
    assign id_op  = id_ir[31:26];
    assign id_rs  = id_ir[25:21];
    assign id_rt  = id_ir[20:16];
    assign id_rd  = id_ir[15:11];
    assign id_imm = {{16{id_ir[15]}}, id_ir[15:0]};

    assign id_rr = (id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT})
                 || (MUL_EN && id_op == OP_MUL);
    assign id_ri = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI, OP_LW};

    always_comb begin
        id_dst = 5'd0;
        unique case (1'b1)
            id_rr:   id_dst = id_rd;
            id_ri:   id_dst = id_rt;
            default: id_dst = 5'd0;
        endcase
    end

    always_comb begin
        rf_a = (id_rs == 5'd0) ? 32'd0 : RegBank[id_rs];
        rf_b = (id_rt == 5'd0) ? 32'd0 : RegBank[id_rt];
        if (wb_we && mem_wb.dst == id_rs) rf_a = wb_val;
        if (wb_we && mem_wb.dst == id_rt) rf_b = wb_val;
    end

    logic        mem_fwd;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] alu;
    logic        taken;
    logic [31:0] target;
    logic        hlt_in_flight;

    // a load's EX/MEM value is its address, so it is never forwarded
    assign mem_fwd = (ex_mem.dst != 5'd0) && (ex_mem.op != OP_LW);

    always_comb begin
        fa = id_ex.a;
        fb = id_ex.b;
        if (mem_fwd && ex_mem.dst == id_ex.rs) fa = ex_mem.alu;
        else if (wb_we && mem_wb.dst == id_ex.rs) fa = wb_val;
        if (mem_fwd && ex_mem.dst == id_ex.rt) fb = ex_mem.alu;
        else if (wb_we && mem_wb.dst == id_ex.rt) fb = wb_val;
    end

    always_comb begin
        alu = 32'd0;
        unique case (id_ex.op)
            OP_ADD:  alu = fa + fb;
            OP_SUB:  alu = fa - fb;
            OP_AND:  alu = fa & fb;
            OP_OR:   alu = fa | fb;
            OP_SLT:  alu = {31'd0, $signed(fa) < $signed(fb)};
`ifdef MIPS32_MUL_EN
            OP_MUL:  alu = fa * fb;
`endif
            OP_ADDI, OP_LW, OP_SW: alu = fa + id_ex.imm;
            OP_SUBI: alu = fa - id_ex.imm;
            OP_SLTI: alu = {31'd0, $signed(fa) < $signed(id_ex.imm)};
            default: alu = 32'd0;
        endcase
    end

    assign taken  = !HALTED
                  && ((id_ex.op == OP_BNEQZ && fa != 32'd0)
                   || (id_ex.op == OP_BEQZ && fa == 32'd0));
    assign target = id_ex.npc + id_ex.imm;

    assign hlt_in_flight = (id_op == OP_HLT) || (id_ex.op == OP_HLT)
                         || (ex_mem.op == OP_HLT) || (mem_wb.op == OP_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= RESET_PC;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id        <= '{ir: NOP_IR, default: '0};
            id_ex        <= '{op: OP_OR, default: '0};
            ex_mem       <= '{op: OP_OR, default: '0};
            mem_wb       <= '{op: OP_OR, default: '0};
        end else if (HALTED) begin
            TAKEN_BRANCH <= 1'b0;
        end else begin
            PC           <= taken ? target : PC + 32'd1;
            TAKEN_BRANCH <= taken;
            // nothing younger than a HLT is allowed into the pipe
            if_id.ir     <= hlt_in_flight ? NOP_IR : Mem[widx(PC)];
            if_id.npc    <= PC + 32'd1;
            if (taken) begin
                id_ex <= '{op: OP_OR, default: '0};
            end else begin
                id_ex <= '{op: id_op, rs: id_rs, rt: id_rt, dst: id_dst,
                           npc: if_id.npc, a: rf_a, b: rf_b, imm: id_imm};
            end
            ex_mem <= '{op: id_ex.op, dst: id_ex.dst, alu: alu, b: fb};
            mem_wb <= '{op: ex_mem.op, dst: ex_mem.dst, alu: ex_mem.alu,
                        lmd: Mem[widx(ex_mem.alu)]};
            if (mem_wb.op == OP_HLT) HALTED <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_we) RegBank[mem_wb.dst] <= wb_val;
        if (!HALTED && ex_mem.op == OP_SW) Mem[widx(ex_mem.alu)] <= ex_mem.b;
    end

    assign halted = HALTED;

endmodule

// File: tb/tb_mips32_pipeline.sv
// tb_mips32_pipeline: directed vectors and program sequences for mips32_pipeline.
module tb_mips32_pipeline;
    localparam logic [31:0] HLT = 32'hfc000000;
    localparam logic [31:0] NOP = 32'h0ce77800;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010;
    localparam logic [5:0] OR_ = 6'b000011, SLT = 6'b000100, MUL = 6'b000101;
    localparam logic [5:0] LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010;
    localparam logic [5:0] SUBI = 6'b001011, SLTI = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [4:0]  r;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halted;
    int nvec = 0;
    int nerr = 0;
    logic [31:0] prog[$];
    vec_t vt[$];
    logic [31:0] mul_exp;
    logic [31:0] fact_exp;

    mips32_pipeline dut (.clk(clk), .rst_n(rst_n), .halted(halted));

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 1024; i++) dut.Mem[i] = HLT;
        for (int i = 0; i < 32; i++) dut.RegBank[i] = 32'(i);
    endtask

    task automatic load_release();
        for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " halt"}, 32'(halted), 32'd1);
    endtask

    initial begin
`ifdef MIPS32_MUL_EN
        mul_exp  = 32'hffffffeb;
        fact_exp = 32'd5040;
`else
        mul_exp  = 32'd5;
        fact_exp = 32'd1;
`endif
        @(posedge clk);
        #1;
        check("rst pc", dut.PC, 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst taken", 32'(dut.TAKEN_BRANCH), 32'd0);

        // R1=7 R2=-3 R3=0x0f0f00ff R4=0x00ff0f0f, R5 keeps 5
        vt.push_back('{"add", rr(ADD, 5'd5, 5'd1, 5'd2), 5'd5, 32'd4});
        vt.push_back('{"sub", rr(SUB, 5'd5, 5'd1, 5'd2), 5'd5, 32'd10});
        vt.push_back('{"and", rr(AND_, 5'd5, 5'd3, 5'd4), 5'd5, 32'h000f000f});
        vt.push_back('{"or", rr(OR_, 5'd5, 5'd3, 5'd4), 5'd5, 32'h0fff0fff});
        vt.push_back('{"slt t", rr(SLT, 5'd5, 5'd2, 5'd1), 5'd5, 32'd1});
        vt.push_back('{"slt f", rr(SLT, 5'd5, 5'd1, 5'd2), 5'd5, 32'd0});
        vt.push_back('{"addi neg", ri(ADDI, 5'd5, 5'd1, 16'hfff8), 5'd5, 32'hffffffff});
        vt.push_back('{"subi", ri(SUBI, 5'd5, 5'd1, 16'd7), 5'd5, 32'd0});
        vt.push_back('{"slti", ri(SLTI, 5'd5, 5'd2, 16'hfffe), 5'd5, 32'd1});
        vt.push_back('{"addi sx", ri(ADDI, 5'd5, 5'd2, 16'd5), 5'd5, 32'd2});
        vt.push_back('{"r0 write", rr(ADD, 5'd0, 5'd1, 5'd1), 5'd0, 32'd0});
        vt.push_back('{"mul", rr(MUL, 5'd5, 5'd1, 5'd2), 5'd5, mul_exp});
        vt.push_back('{"undef op", {6'b010000, 5'd1, 5'd5, 16'd1}, 5'd5, 32'd5});

        foreach (vt[k]) begin
            enter_reset();
            dut.RegBank[1] = 32'd7;
            dut.RegBank[2] = 32'hfffffffd;
            dut.RegBank[3] = 32'h0f0f00ff;
            dut.RegBank[4] = 32'h00ff0f0f;
            prog = '{vt[k].ir, HLT};
            load_release();
            wait_halt(vt[k].name, 30);
            check(vt[k].name, dut.RegBank[vt[k].r], vt[k].exp);
        end

        enter_reset();
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, NOP, NOP,
                 32'h00222000, NOP, 32'h00832800, HLT};
        load_release();
        wait_halt("progA", 40);
        check("progA r1", dut.RegBank[1], 32'd10);
        check("progA r2", dut.RegBank[2], 32'd20);
        check("progA r3", dut.RegBank[3], 32'd25);
        check("progA r4", dut.RegBank[4], 32'd30);
        check("progA r5", dut.RegBank[5], 32'd55);
        check("progA r0", dut.RegBank[0], 32'd0);
        check("halt pc", dut.PC, 32'd13);
        repeat (3) @(posedge clk);
        #1;
        check("halt pc hold", dut.PC, 32'd13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async halted", 32'(halted), 32'd0);
        check("async pc", dut.PC, 32'd0);
        check("async keep r5", dut.RegBank[5], 32'd55);

        enter_reset();
        prog = '{ri(ADDI, 5'd1, 5'd0, 16'd5), rr(ADD, 5'd2, 5'd1, 5'd1), HLT};
        load_release();
        wait_halt("fwd1", 30);
        check("fwd1 r2", dut.RegBank[2], 32'd10);

        enter_reset();
        dut.Mem[120] = 32'd85;
        prog = '{ri(ADDI, 5'd10, 5'd0, 16'd120), ri(LW, 5'd2, 5'd10, 16'd0), NOP,
                 ri(ADDI, 5'd2, 5'd2, 16'd45), ri(SW, 5'd2, 5'd10, 16'd1), HLT};
        load_release();
        wait_halt("lwsw", 40);
        check("lwsw mem121", dut.Mem[121], 32'd130);
        check("lwsw r2", dut.RegBank[2], 32'd130);

        begin
            int n;
            enter_reset();
            dut.RegBank[8] = 32'haa;
            dut.RegBank[9] = 32'haa;
            prog = '{ri(BEQZ, 5'd0, 5'd0, 16'd2), ri(ADDI, 5'd8, 5'd0, 16'd1),
                     ri(ADDI, 5'd9, 5'd0, 16'd1), ri(ADDI, 5'd11, 5'd0, 16'd7), HLT};
            load_release();
            n = 0;
            while (!dut.TAKEN_BRANCH && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("br latency", 32'(n), 32'd3);
            check("br pc target", dut.PC, 32'd3);
            @(posedge clk);
            #1;
            check("br pulse width", 32'(dut.TAKEN_BRANCH), 32'd0);
            wait_halt("br", 30);
            check("br squash r8", dut.RegBank[8], 32'haa);
            check("br squash r9", dut.RegBank[9], 32'haa);
            check("br target r11", dut.RegBank[11], 32'd7);
        end

        enter_reset();
        prog = '{ri(BNEQZ, 5'd0, 5'd0, 16'd2), ri(ADDI, 5'd8, 5'd0, 16'd1),
                 ri(ADDI, 5'd9, 5'd0, 16'd1), HLT};
        load_release();
        wait_halt("bnt", 30);
        check("bnt r8", dut.RegBank[8], 32'd1);
        check("bnt r9", dut.RegBank[9], 32'd1);

        enter_reset();
        dut.Mem[50] = 32'hdead;
        prog = '{ri(ADDI, 5'd13, 5'd0, 16'd50), HLT, ri(ADDI, 5'd12, 5'd0, 16'd9),
                 ri(SW, 5'd13, 5'd13, 16'd0)};
        load_release();
        wait_halt("hltsq", 30);
        check("hltsq r13", dut.RegBank[13], 32'd50);
        check("hltsq r12", dut.RegBank[12], 32'd12);
        check("hltsq mem50", dut.Mem[50], 32'hdead);

        enter_reset();
        dut.Mem[200] = 32'd7;
        prog = '{ri(ADDI, 5'd10, 5'd0, 16'd200), ri(ADDI, 5'd2, 5'd0, 16'd1), NOP,
                 ri(LW, 5'd3, 5'd10, 16'd0), NOP, rr(MUL, 5'd2, 5'd2, 5'd3),
                 ri(SUBI, 5'd3, 5'd3, 16'd1), NOP, ri(BNEQZ, 5'd0, 5'd3, 16'hfffc),
                 ri(SW, 5'd2, 5'd10, 16'hfffe), HLT};
        load_release();
        wait_halt("fact", 400);
        check("fact mem198", dut.Mem[198], fact_exp);
        check("fact r3", dut.RegBank[3], 32'd0);

        enter_reset();
        dut.RegBank[1] = 32'd0;
        prog = '{ri(ADDI, 5'd1, 5'd1, 16'd1), ri(BEQZ, 5'd0, 5'd0, 16'hfffe)};
        load_release();
        repeat (18) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst pc", dut.PC, 32'd0);
        check("mid rst halted", 32'(halted), 32'd0);
        check("mid rst keep r1", dut.RegBank[1], 32'd4);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart pc", dut.PC, 32'd1);
        repeat (17) @(posedge clk);
        #1;
        check("restart r1", dut.RegBank[1], 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
